mem_dump_reader: RTL and testbench
==================================

# mem_dump_reader

Readback engine for the single-cycle RISC-V test top: after a program runs, it freezes the CPU, walks a word-aligned range of data memory, and streams each 32-bit word out on a valid/ready interface. It is the read-direction counterpart of the external preload path, which writes into data memory while the CPU is held. It shares the data-memory address mux and the word-access setting with that path.

## Interface
- ADDR_W, 32, data memory byte-address width
- CNT_W, 16, width of the word-count field
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- start  in  1  single-cycle request to begin a dump; ignored while busy
- abort  in  1  synchronous; cancels a dump in progress
- base_adr  in  ADDR_W  first byte address; bits [1:0] are forced to 0
- word_count  in  CNT_W  number of words to dump; 0 is legal
- mem_adr  out  ADDR_W  address driven to data memory; the top muxes it onto DataAdr while cpu_hold=1
- mem_rdata  in  32  data-memory read data, combinational from mem_adr
- cpu_hold  out  1  holds the CPU in reset and selects mem_adr; equals busy
- busy  out  1  dump in progress
- done  out  1  one-cycle pulse after the last word is accepted
- out_valid  out  1  out_data is valid
- out_ready  in  1  consumer accepts the word
- out_data  out  32  streamed word
- out_last  out  1  marks the final word of the dump

## Operation
- States:
  - IDLE: wait for start.
  - READ: issue memory reads.
  - DRAIN: all reads issued; wait for the FIFO to empty.
  - FIN: one cycle that asserts done, then return to IDLE.
- IDLE, start=1:
  - Latch rem=word_count and adr={base_adr[ADDR_W-1:2],2'b00}.
  - Go to READ, or to FIN if word_count==0. That case produces no stream words, and done still pulses.
- READ:
  - mem_adr=adr.
  - A read fires when the FIFO is not full, or is full and being popped this cycle.
  - On a fire: push {mem_rdata, rem==1}, adr+=4, rem-=1. When rem reaches 0, go to DRAIN.
- DRAIN: when the FIFO is empty and no push is pending, go to FIN.
- Address arithmetic is modulo 2^ADDR_W; wrapping from 0xFFFF_FFFC to 0 is legal. Only word accesses are made, with no byte or halfword lanes.
- Output follows the valid/ready rule: once out_valid=1, out_data and out_last hold stable until out_valid&&out_ready. out_valid never depends on out_ready.
- abort in READ or DRAIN:
  - Flush the FIFO, deassert out_valid, and go to IDLE at the next edge. done does not pulse.
  - abort in IDLE or FIN has no effect.
- start is ignored in any state other than IDLE, including FIN.
- In IDLE, mem_adr holds its last value; it is a don't-care for the top because cpu_hold=0.
- The block never writes memory. The top forces word-access funct3 (3'b010) and MemWrite=0 while cpu_hold=1.

## Timing
- Reset values: state=IDLE, busy=0, cpu_hold=0, done=0, out_valid=0, out_last=0, out_data=0, mem_adr=0, FIFO empty.
- start sampled at edge E0 → busy=1 and mem_adr=base during cycle 1. Word 0 is captured at E1, and out_valid=1 from cycle 2.
- Throughput is 1 word/cycle with out_ready held high.
- With out_ready high throughout, the last handshake for N words occurs in cycle N+1. done pulses in cycle N+2 (the FIN cycle) and busy drops in cycle N+3.
- Simultaneous push and pop on a full FIFO is legal; the count is unchanged.
- abort on the same cycle as a handshake: that word counts as delivered, then everything is flushed.
- Async reset mid-dump: every output returns to its reset value immediately, and cpu_hold releases.

## Structure
- Shared package riscv_dbg_pkg holds:
  - state encoding (IDLE=2'd0, READ=2'd1, DRAIN=2'd2, FIN=2'd3);
  - WORD_BYTES=4;
  - the funct3 constant for word access (3'b010), also used by the preload path.
- Sub-module dump_fifo: a 2-entry, 33-bit (data+last) FIFO with push, pop, full, empty and flush.
  - Its head entry drives out_data/out_last directly.
  - Its reset is asynchronous and active-low.

## Test plan
- Memory 0x00..0x0C preloaded with 0x11,0x22,0x33,0x44; start with base=0, count=4, out_ready=1 → words stream in cycles 2–5, out_last on 0x44, done in cycle 6.
- Same dump with out_ready toggling 1,0,0,1,… → no word is lost or duplicated, and out_data holds stable while out_valid && !out_ready.
- base=0x0000_0103, count=2 → reads 0x100 and 0x104; base=0xFFFF_FFFC, count=2 → reads 0xFFFF_FFFC then 0x0.
- count=0 → done pulses one cycle after start, out_valid never rises, and busy is high for one cycle.
- abort in the middle of a 16-word dump with out_ready=0 → out_valid=0 next cycle, no done, IDLE; a following start with count=1 works.
- reset low asynchronously while out_valid=1 → all outputs reset without waiting for a clock edge; a start after reset release behaves normally.

Source files
------------

// File: rtl/riscv_dbg_pkg.sv
// Shared definitions for the debug readback/preload paths of the single-cycle RISC-V top.
// Holds the dump FSM encoding, word geometry and the stream entry layout.
package riscv_dbg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } dumpState_t;

  localparam int WORD_BYTES = 4;

  // funct3 for word loads/stores; the preload path forces the same value
  localparam logic [2:0] FUNCT3_WORD = 3'b010;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } dumpWord_t;

endpackage

// File: rtl/dump_fifo.sv
// Two-entry FIFO between the memory read side and the output stream.
// The head entry is presented combinationally; flush empties it in one edge.
module dump_fifo
  import riscv_dbg_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  logic      pop,
  input  logic      flush,
  input  dumpWord_t wrData,
  output dumpWord_t headData,
  output logic      full,
  output logic      empty
);

  logic       wrPtrReg;
  logic       rdPtrReg;
  logic [1:0] countReg;
  logic [1:0] countNext;
  logic       doPush;
  logic       doPop;

  assign full   = (countReg == 2'd2);
  assign empty  = (countReg == 2'd0);
  assign doPop  = pop && !empty;
  // a full FIFO still accepts a push when the head leaves on the same edge
  assign doPush = push && (!full || doPop);

  always_comb begin
    countNext = countReg;
    case ({doPush, doPop})
      2'b10:   countNext = countReg + 2'd1;
      2'b01:   countNext = countReg - 2'd1;
      default: countNext = countReg;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtrReg <= 1'b0;
      rdPtrReg <= 1'b0;
      countReg <= 2'd0;
    end else if (flush) begin
      wrPtrReg <= 1'b0;
      rdPtrReg <= 1'b0;
      countReg <= 2'd0;
    end else begin
      if (doPush) wrPtrReg <= ~wrPtrReg;
      if (doPop)  rdPtrReg <= ~rdPtrReg;
      countReg <= countNext;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      dumpWord_t entryReg;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          entryReg <= '0;
        end else if (doPush && !flush && (wrPtrReg == 1'(gi))) begin
          entryReg <= wrData;
        end
      end
    end
  endgenerate

  assign headData = rdPtrReg ? g_entry[1].entryReg : g_entry[0].entryReg;

endmodule

// File: rtl/mem_dump_reader.sv
// Data-memory readback engine: holds the CPU, walks a word-aligned range and
// streams each word out over valid/ready, marking the final one with out_last.
module mem_dump_reader
  import riscv_dbg_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_adr,
  input  logic [CNT_W-1:0]  word_count,
  output logic [ADDR_W-1:0] mem_adr,
  input  logic [31:0]       mem_rdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic              out_last
);

  dumpState_t        stateReg;
  dumpState_t        stateNext;
  logic [ADDR_W-1:0] adrReg;
  logic [ADDR_W-1:0] adrNext;
  logic [CNT_W-1:0]  remReg;
  logic [CNT_W-1:0]  remNext;

  logic      fifoPush;
  logic      fifoPop;
  logic      fifoFlush;
  logic      fifoFull;
  logic      fifoEmpty;
  dumpWord_t pushWord;
  dumpWord_t headWord;

  assign fifoPop       = !fifoEmpty && out_ready;
  assign pushWord.data = mem_rdata;
  assign pushWord.last = (remReg == CNT_W'(1));

  always_comb begin
    stateNext = stateReg;
    adrNext   = adrReg;
    remNext   = remReg;
    fifoPush  = 1'b0;
    fifoFlush = 1'b0;
    case (stateReg)
      IDLE: begin
        if (start) begin
          adrNext   = base_adr & ~ADDR_W'(WORD_BYTES - 1);
          remNext   = word_count;
          stateNext = (word_count == '0) ? FIN : READ;
        end
      end
      READ: begin
        if (abort) begin
          fifoFlush = 1'b1;
          stateNext = IDLE;
        end else if (!fifoFull || fifoPop) begin
          fifoPush = 1'b1;
          adrNext  = adrReg + ADDR_W'(WORD_BYTES);
          remNext  = remReg - CNT_W'(1);
          if (remReg == CNT_W'(1)) stateNext = DRAIN;
        end
      end
      DRAIN: begin
        if (abort) begin
          fifoFlush = 1'b1;
          stateNext = IDLE;
        // leave as the last entry is handed over so done lands right after it
        end else if (fifoEmpty || (fifoPop && !fifoFull)) begin
          stateNext = FIN;
        end
      end
      FIN: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateReg <= IDLE;
      adrReg   <= '0;
      remReg   <= '0;
    end else begin
      stateReg <= stateNext;
      adrReg   <= adrNext;
      remReg   <= remNext;
    end
  end

  dump_fifo uFifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifoPush),
    .pop      (fifoPop),
    .flush    (fifoFlush),
    .wrData   (pushWord),
    .headData (headWord),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

  assign busy      = (stateReg != IDLE);
  assign cpu_hold  = busy;
  assign done      = (stateReg == FIN);
  assign mem_adr   = adrReg;
  assign out_valid = !fifoEmpty;
  assign out_data  = headWord.data;
  assign out_last  = headWord.last && !fifoEmpty;

endmodule

// File: tb/tb_mem_dump_reader.sv
// Randomized self-checking bench for mem_dump_reader: a queue model of the
// expected word stream plus per-cycle logs for literal timing checks.
`timescale 1ns/1ps
module tb_mem_dump_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] base_adr = '0;
  logic [15:0] word_count = '0;
  logic [31:0] mem_adr;
  logic [31:0] mem_rdata;
  logic [31:0] out_data;
  logic        cpu_hold, busy, done, out_valid, out_last;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h11;
      32'h4:   return 32'h22;
      32'h8:   return 32'h33;
      32'hC:   return 32'h44;
      default: return (a * 32'h9E3779B1) ^ 32'h5A5A_1234;
    endcase
  endfunction

  assign mem_rdata = memWord(mem_adr);

  mem_dump_reader #(.ADDR_W(32), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .base_adr   (base_adr),
    .word_count (word_count),
    .mem_adr    (mem_adr),
    .mem_rdata  (mem_rdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // expected stream: {data, last}, front = next word to appear
  logic [32:0] expQ[$];
  bit          doneExpected = 0;
  int          deliveredCnt = 0;
  int          doneCnt = 0;

  task automatic modelStart(input logic [31:0] base, input int n);
    logic [31:0] a;
    a = base & 32'hFFFF_FFFC;
    for (int i = 0; i < n; i++) begin
      expQ.push_back({memWord(a), (i == n - 1)});
      a = a + 32'd4;
    end
    doneExpected = 1;
  endtask

  // stream checker: runs every negedge, away from the active edge
  initial begin
    bit          prevHold;
    logic [31:0] prevData;
    logic        prevLast;
    prevHold = 0;
    prevData = '0;
    prevLast = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prevHold = 0;
      end else begin
        chk("cpu_hold_vs_busy", 32'(cpu_hold), 32'(busy));
        if (prevHold) begin
          chk("stall_valid", 32'(out_valid), 32'd1);
          chk("stall_data", out_data, prevData);
          chk("stall_last", 32'(out_last), 32'(prevLast));
        end
        if (out_valid) begin
          if (expQ.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_word: got 0x%08h, expected no word", out_data);
          end else begin
            chk("stream_data", out_data, expQ[0][32:1]);
            chk("stream_last", 32'(out_last), 32'(expQ[0][0]));
          end
          if (out_ready) begin
            if (expQ.size() > 0) void'(expQ.pop_front());
            deliveredCnt++;
          end
        end
        prevHold = out_valid && !out_ready;
        prevData = out_data;
        prevLast = out_last;
        if (done) begin
          doneCnt++;
          chk("done_expected", 32'(doneExpected), 32'd1);
          chk("done_queue_empty", 32'(expQ.size()), 32'd0);
          doneExpected = 0;
        end
        if (abort && busy && !done) begin
          expQ.delete();
          doneExpected = 0;
          prevHold = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] logData[64];
  logic [31:0] logAdr[64];
  bit          logValid[64], logLast[64], logDone[64], logBusy[64];
  int          endCycle;
  bit          anyValid;

  // mode: 0 ready high, 1 ready 1,0,0 repeating, 2 random, 3 ready low
  task automatic runDump(input logic [31:0] base, input int n, input int mode,
                         input int abortAt, output int doneCycle, output bit aborted);
    int c;
    bit fin;
    deliveredCnt = 0;
    doneCnt = 0;
    doneCycle = -1;
    aborted = 0;
    anyValid = 0;
    endCycle = -1;
    for (int i = 0; i < 64; i++) begin
      logValid[i] = 0; logLast[i] = 0; logDone[i] = 0; logBusy[i] = 0;
      logData[i] = '0; logAdr[i] = '0;
    end
    base_adr = base;
    word_count = 16'(n);
    out_ready = 1'b1;
    start = 1'b1;
    modelStart(base, n);
    tick();
    start = 1'b0;
    c = 1;
    fin = 0;
    while (!fin && c < 400) begin
      if (c < 64) begin
        logValid[c] = out_valid; logLast[c] = out_last; logDone[c] = done;
        logBusy[c] = busy; logData[c] = out_data; logAdr[c] = mem_adr;
      end
      if (out_valid) anyValid = 1;
      if (!busy) begin
        fin = 1;
        endCycle = c;
      end else begin
        if (done) doneCycle = c;
        abort = (c == abortAt);
        if (abort && !done) aborted = 1;
        case (mode)
          0:       out_ready = 1'b1;
          1:       out_ready = (c % 3 == 1);
          2:       out_ready = 1'($urandom_range(0, 1));
          default: out_ready = 1'b0;
        endcase
        tick();
        abort = 1'b0;
        if (aborted) begin
          chk("abort_valid", 32'(out_valid), 32'd0);
          chk("abort_busy", 32'(busy), 32'd0);
          fin = 1;
          endCycle = c + 1;
        end
        c++;
      end
    end
    if (!fin) begin
      compared++;
      mismatched++;
      $display("FAIL dump_timeout: got busy after %0d cycles, expected idle", c);
    end
    if (aborted) begin
      chk("abort_no_done", 32'(doneCnt), 32'd0);
    end else begin
      chk("done_count", 32'(doneCnt), 32'd1);
      chk("delivered", 32'(deliveredCnt), 32'(n));
      chk("queue_drained", 32'(expQ.size()), 32'd0);
    end
  endtask

  initial begin
    int  dc;
    bit  ab;
    int  n;
    int  mode;
    int  abortAt;
    logic [31:0] base;

    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hold", 32'(cpu_hold), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_adr", mem_adr, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    // basic 4-word dump with the literal cycle timeline
    runDump(32'h0, 4, 0, -1, dc, ab);
    chk("t1_done_cycle", 32'(dc), 32'd6);
    chk("t1_c1_busy", 32'(logBusy[1]), 32'd1);
    chk("t1_c1_valid", 32'(logValid[1]), 32'd0);
    chk("t1_c1_adr", logAdr[1], 32'h0);
    chk("t1_c2_data", logData[2], 32'h11);
    chk("t1_c3_data", logData[3], 32'h22);
    chk("t1_c4_data", logData[4], 32'h33);
    chk("t1_c5_data", logData[5], 32'h44);
    chk("t1_c4_last", 32'(logLast[4]), 32'd0);
    chk("t1_c5_last", 32'(logLast[5]), 32'd1);
    chk("t1_c5_valid", 32'(logValid[5]), 32'd1);
    chk("t1_c6_valid", 32'(logValid[6]), 32'd0);
    chk("t1_end_cycle", 32'(endCycle), 32'd7);

    // same dump with back-pressure
    runDump(32'h0, 4, 1, -1, dc, ab);

    // unaligned base and address wrap
    runDump(32'h0000_0103, 2, 0, -1, dc, ab);
    chk("t3_c1_adr", logAdr[1], 32'h100);
    chk("t3_c2_adr", logAdr[2], 32'h104);
    runDump(32'hFFFF_FFFC, 2, 0, -1, dc, ab);
    chk("t3w_c1_adr", logAdr[1], 32'hFFFF_FFFC);
    chk("t3w_c2_adr", logAdr[2], 32'h0);

    // zero-length dump
    runDump(32'h40, 0, 0, -1, dc, ab);
    chk("t4_done_cycle", 32'(dc), 32'd1);
    chk("t4_end_cycle", 32'(endCycle), 32'd2);
    chk("t4_no_valid", 32'(anyValid), 32'd0);

    // abort mid-dump under back-pressure, then a 1-word dump
    runDump(32'h200, 16, 3, 6, dc, ab);
    chk("t5_aborted", 32'(ab), 32'd1);
    runDump(32'h40, 1, 0, -1, dc, ab);
    chk("t5_next_done_cycle", 32'(dc), 32'd3);

    // asynchronous reset while a word is waiting
    base_adr = 32'h300;
    word_count = 16'd8;
    out_ready = 1'b0;
    start = 1'b1;
    modelStart(32'h300, 8);
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("t6_valid_before", 32'(out_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_hold", 32'(cpu_hold), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_last", 32'(out_last), 32'd0);
    chk("t6_data", out_data, 32'd0);
    chk("t6_adr", mem_adr, 32'd0);
    expQ.delete();
    doneExpected = 0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    runDump(32'h0, 4, 0, -1, dc, ab);
    chk("t6_after_done_cycle", 32'(dc), 32'd6);

    // randomized dumps
    for (int k = 0; k < 40; k++) begin
      base = $urandom;
      n = $urandom_range(0, 12);
      mode = $urandom_range(0, 2);
      abortAt = (mode != 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, n + 3) : -1;
      runDump(base, n, mode, abortAt, dc, ab);
      if (mode == 0) chk("rand_done_cycle", 32'(dc), (n == 0) ? 32'd1 : 32'(n + 2));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
